// File: rtl/sine_rom_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// svpwm_pkg : shared widths, ROM request tags and scheduler states
// Rev 1.0
// ============================================================================
package svpwm_pkg;

  localparam int ANGLE_W         = 10;
  localparam int DATA_W          = 16;
  localparam int IDX_MAX_DEFAULT = 960;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_T1   = 2'd1,
    TAG_T2   = 2'd2,
    TAG_AUX  = 2'd3
  } tag_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE1 = 2'd1,
    ST_ISSUE2 = 2'd2
  } state_e;

  function automatic logic is_frame_tag(input tag_e t);
    return (t == TAG_T1) || (t == TAG_T2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_rom_scheduler_tag_pipe.sv
`default_nettype none
// ============================================================================
// rom_tag_pipe : LAT-deep tag shift register aligned with ROM read latency
// Rev 1.0
// ============================================================================
module rom_tag_pipe
  import svpwm_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       drop_frame_i,
  input  logic [1:0] tag_i,
  output logic [1:0] tag_o
);

  tag_e pipe_q [LAT];

  // Frame tags are scrubbed both on entry and while travelling so a
  // disabled frame can never commit, whatever stage it has reached.
  function automatic tag_e mask_tag(input tag_e t, input logic drop);
    return (drop && is_frame_tag(t)) ? TAG_NONE : t;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= TAG_NONE;
    end else begin
      pipe_q[0] <= mask_tag(tag_e'(tag_i), drop_frame_i);
      for (int i = 1; i < LAT; i++) pipe_q[i] <= mask_tag(pipe_q[i-1], drop_frame_i);
    end
  end

  assign tag_o = mask_tag(pipe_q[LAT-1], drop_frame_i);

endmodule
`default_nettype wire

// File: rtl/sine_rom_scheduler.sv
`default_nettype none
// ============================================================================
// sine_rom_scheduler : shares one sine ROM between the T1/T2 frame lookups
//                      and an aux requester, committing sin_u1/sin_u2 together
// Rev 1.0
// ============================================================================
module sine_rom_scheduler
  import svpwm_pkg::*;
#(
  parameter int ROM_LAT = 2,
  parameter int IDX_MAX = IDX_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               synchr_clk,
  input  logic [ANGLE_W-1:0] sin_t1,
  input  logic [ANGLE_W-1:0] sin_t2,
  output logic [DATA_W-1:0]  sin_u1,
  output logic [DATA_W-1:0]  sin_u2,
  output logic               sin_valid,
  input  logic               aux_req,
  input  logic [ANGLE_W-1:0] aux_addr,
  output logic               aux_ack,
  output logic [DATA_W-1:0]  aux_data,
  output logic               rom_rd,
  output logic [ANGLE_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               addr_err,
  output logic               overrun
);

  localparam logic [ANGLE_W-1:0] c_idx_max = ANGLE_W'(IDX_MAX);

  state_e              state_q, state_d;
  logic                old_synchr_q;
  logic [ANGLE_W-1:0]  addr1_q, addr2_q;
  logic [DATA_W-1:0]   d1_q;
  logic [DATA_W-1:0]   sin_u1_q, sin_u2_q, aux_data_q;
  logic                sin_valid_q, aux_ack_q, aux_busy_q;
  logic                addr_err_q, overrun_q;

  logic                w_trigger;
  logic                w_t1_clamp, w_t2_clamp, w_aux_clamp;
  logic [ANGLE_W-1:0]  w_t1_idx, w_t2_idx, w_aux_idx;
  logic                w_rom_rd, w_aux_issue;
  logic [ANGLE_W-1:0]  w_rom_addr;
  tag_e                w_issue_tag, w_exit_tag;
  logic [1:0]          w_exit_raw;

  assign w_trigger   = old_synchr_q & ~synchr_clk & enable;
  assign w_t1_clamp  = sin_t1 > c_idx_max;
  assign w_t2_clamp  = sin_t2 > c_idx_max;
  assign w_aux_clamp = aux_addr > c_idx_max;
  assign w_t1_idx    = w_t1_clamp  ? c_idx_max : sin_t1;
  assign w_t2_idx    = w_t2_clamp  ? c_idx_max : sin_t2;
  assign w_aux_idx   = w_aux_clamp ? c_idx_max : aux_addr;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Aux waits out the cycle its ack is visible, since the requester only
  // drops aux_req after seeing that ack.
  always_comb begin
    state_d     = state_q;
    w_rom_rd    = 1'b0;
    w_rom_addr  = '0;
    w_issue_tag = TAG_NONE;
    w_aux_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_trigger) begin
          state_d = ST_ISSUE1;
        end else if (aux_req && !aux_busy_q && !aux_ack_q) begin
          w_aux_issue = 1'b1;
          w_rom_rd    = 1'b1;
          w_rom_addr  = w_aux_idx;
          w_issue_tag = TAG_AUX;
        end
      end
      ST_ISSUE1: begin
        w_rom_rd    = 1'b1;
        w_rom_addr  = addr1_q;
        w_issue_tag = TAG_T1;
        state_d     = ST_ISSUE2;
      end
      ST_ISSUE2: begin
        w_rom_rd    = 1'b1;
        w_rom_addr  = addr2_q;
        w_issue_tag = TAG_T2;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      w_rom_rd    = 1'b0;
      w_rom_addr  = '0;
      w_issue_tag = TAG_NONE;
      w_aux_issue = 1'b0;
    end
  end

  rom_tag_pipe #(
    .LAT (ROM_LAT)
  ) u_tag_pipe (
    .clk_i        (clk),
    .rst_i        (reset),
    .drop_frame_i (~enable),
    .tag_i        (w_issue_tag),
    .tag_o        (w_exit_raw)
  );

  assign w_exit_tag = tag_e'(w_exit_raw);

  always_ff @(posedge clk) begin
    if (reset) begin
      old_synchr_q <= 1'b0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      d1_q         <= '0;
      sin_u1_q     <= '0;
      sin_u2_q     <= '0;
      sin_valid_q  <= 1'b0;
      aux_ack_q    <= 1'b0;
      aux_data_q   <= '0;
      aux_busy_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      old_synchr_q <= synchr_clk;
      if (w_trigger && state_q == ST_IDLE) begin
        addr1_q <= w_t1_idx;
        addr2_q <= w_t2_idx;
        if (w_t1_clamp || w_t2_clamp) addr_err_q <= 1'b1;
      end
      if (w_trigger && state_q != ST_IDLE) overrun_q <= 1'b1;
      if (w_aux_issue && w_aux_clamp) addr_err_q <= 1'b1;

      if (w_aux_issue)    aux_busy_q <= 1'b1;
      else if (aux_ack_q) aux_busy_q <= 1'b0;

      aux_ack_q <= (w_exit_tag == TAG_AUX);
      if (w_exit_tag == TAG_AUX) aux_data_q <= rom_data;
      if (w_exit_tag == TAG_T1)  d1_q <= rom_data;

      // T2 return commits the pair directly, keeping the frame latency tight.
      sin_valid_q <= 1'b0;
      if (!enable) begin
        sin_u1_q <= '0;
        sin_u2_q <= '0;
      end else if (w_exit_tag == TAG_T2) begin
        sin_u1_q    <= d1_q;
        sin_u2_q    <= rom_data;
        sin_valid_q <= 1'b1;
      end
    end
  end

  assign sin_u1    = sin_u1_q;
  assign sin_u2    = sin_u2_q;
  assign sin_valid = sin_valid_q;
  assign aux_ack   = aux_ack_q;
  assign aux_data  = aux_data_q;
  assign rom_rd    = w_rom_rd;
  assign rom_addr  = w_rom_addr;
  assign addr_err  = addr_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_rom_scheduler.sv
`default_nettype none
// ============================================================================
// tb_sine_rom_scheduler : directed self-checking bench for sine_rom_scheduler
// Rev 1.0
// ============================================================================
module tb_sine_rom_scheduler;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset, enable, synchr_clk;
  logic [9:0]  sin_t1, sin_t2, aux_addr, rom_addr;
  logic [15:0] sin_u1, sin_u2, aux_data, rom_data;
  logic        sin_valid, aux_req, aux_ack, rom_rd, addr_err, overrun;

  always #5 clk = ~clk;

  sine_rom_scheduler #(
    .ROM_LAT (L),
    .IDX_MAX (960)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .synchr_clk (synchr_clk),
    .sin_t1     (sin_t1),
    .sin_t2     (sin_t2),
    .sin_u1     (sin_u1),
    .sin_u2     (sin_u2),
    .sin_valid  (sin_valid),
    .aux_req    (aux_req),
    .aux_addr   (aux_addr),
    .aux_ack    (aux_ack),
    .aux_data   (aux_data),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .addr_err   (addr_err),
    .overrun    (overrun)
  );

  // ROM model: data = addr*32, L cycles after the read strobe
  logic [L-1:0] rd_pipe = '0;
  logic [9:0]   addr_pipe [L];
  always @(posedge clk) begin
    rd_pipe[0]   <= rom_rd;
    addr_pipe[0] <= rom_addr;
    for (int i = 1; i < L; i++) begin
      rd_pipe[i]   <= rd_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
  end
  assign rom_data = rd_pipe[L-1] ? (16'(addr_pipe[L-1]) << 5) : 16'h0;

  int          cyc = 0;
  int          valid_cnt = 0, last_valid_cyc = -1;
  int          ack_cnt = 0, last_ack_cyc = -1;
  logic [15:0] last_ack_data = '0;
  logic [9:0]  iss_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rom_rd) iss_q.push_back(rom_addr);
    if (sin_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (aux_ack) begin
      ack_cnt++;
      last_ack_cyc  = cyc;
      last_ack_data = aux_data;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (aux_ack) aux_req = 1'b0;
    end
  endtask

  // Returns in the trigger cycle (synchr_clk just fell), tc = that cycle.
  task automatic fire_frame(input logic [9:0] t1, input logic [9:0] t2,
                            input bit with_aux, output int tc);
    sin_t1     = t1;
    sin_t2     = t2;
    synchr_clk = 1'b1;
    tick();
    synchr_clk = 1'b0;
    if (with_aux) begin
      aux_req  = 1'b1;
      aux_addr = 10'd480;
    end
    tc = cyc;
  endtask

  int tc, rc, v0, a0;

  initial begin
    reset = 1'b1; enable = 1'b0; synchr_clk = 1'b0;
    sin_t1 = '0; sin_t2 = '0; aux_req = 1'b0; aux_addr = '0;
    repeat (3) tick();
    chk("rst_sin_u1", sin_u1, 0);
    chk("rst_sin_u2", sin_u2, 0);
    chk("rst_sin_valid", sin_valid, 0);
    chk("rst_aux_ack", aux_ack, 0);
    chk("rst_rom_rd", rom_rd, 0);
    chk("rst_flags", {addr_err, overrun}, 0);
    reset = 1'b0; enable = 1'b1;
    run(3);

    // basic frame
    iss_q.delete(); v0 = valid_cnt;
    fire_frame(10'd100, 10'd860, 1'b0, tc);
    run(8);
    chk("frame_valid_cnt", valid_cnt - v0, 1);
    chk("frame_latency", last_valid_cyc - tc, L + 3);
    chk("frame_u1", sin_u1, 3200);
    chk("frame_u2", sin_u2, 27520);
    chk("frame_iss_n", iss_q.size(), 2);
    chk("frame_iss0", iss_q[0], 100);
    chk("frame_iss1", iss_q[1], 860);
    chk("frame_addr_err", addr_err, 0);

    // clamp
    iss_q.delete();
    fire_frame(10'd100, 10'd1000, 1'b0, tc);
    run(8);
    chk("clamp_rom_addr", iss_q[1], 960);
    chk("clamp_u2", sin_u2, 30720);
    chk("clamp_addr_err", addr_err, 1);

    // overrun: second falling edge lands on ISSUE2
    chk("ovr_pre", overrun, 0);
    iss_q.delete(); v0 = valid_cnt;
    sin_t1 = 10'd50; sin_t2 = 10'd60;
    synchr_clk = 1'b1; tick();
    synchr_clk = 1'b0; tick();
    synchr_clk = 1'b1; tick();
    synchr_clk = 1'b0;
    run(8);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid_cnt", valid_cnt - v0, 1);
    chk("ovr_iss_n", iss_q.size(), 2);
    chk("ovr_u1", sin_u1, 1600);
    chk("ovr_u2", sin_u2, 1920);

    // contention: aux and trigger in the same cycle
    iss_q.delete(); v0 = valid_cnt; a0 = ack_cnt;
    fire_frame(10'd200, 10'd300, 1'b1, tc);
    run(10);
    chk("cont_iss_n", iss_q.size(), 3);
    chk("cont_iss0", iss_q[0], 200);
    chk("cont_iss1", iss_q[1], 300);
    chk("cont_iss2", iss_q[2], 480);
    chk("cont_ack_cnt", ack_cnt - a0, 1);
    chk("cont_ack_cyc", last_ack_cyc - tc, L + 4);
    chk("cont_ack_data", last_ack_data, 15360);
    chk("cont_valid_cyc", last_valid_cyc - tc, L + 3);
    chk("cont_u1", sin_u1, 6400);
    chk("cont_u2", sin_u2, 9600);

    // enable dropped after ISSUE2, before commit; uncontended aux meanwhile
    iss_q.delete(); v0 = valid_cnt; a0 = ack_cnt;
    fire_frame(10'd400, 10'd500, 1'b0, tc);
    tick(); tick(); tick();
    enable = 1'b0; aux_req = 1'b1; aux_addr = 10'd480; rc = cyc;
    run(10);
    chk("en_valid_cnt", valid_cnt - v0, 0);
    chk("en_u1", sin_u1, 0);
    chk("en_u2", sin_u2, 0);
    chk("en_ack_cnt", ack_cnt - a0, 1);
    chk("en_ack_lat", last_ack_cyc - rc, L + 1);
    chk("en_ack_data", last_ack_data, 15360);
    chk("en_addr_err_sticky", addr_err, 1);

    // frame after re-enable
    enable = 1'b1; run(3);
    v0 = valid_cnt;
    fire_frame(10'd100, 10'd860, 1'b0, tc);
    run(8);
    chk("reen_valid_cnt", valid_cnt - v0, 1);
    chk("reen_u1", sin_u1, 3200);

    // reset in the cycle after ISSUE1
    v0 = valid_cnt;
    fire_frame(10'd100, 10'd860, 1'b0, tc);
    tick(); tick();
    reset = 1'b1;
    #3;
    chk("mrst_rom_rd", rom_rd, 0);
    tick();
    reset = 1'b0;
    run(8);
    chk("mrst_valid_cnt", valid_cnt - v0, 0);
    chk("mrst_u1", sin_u1, 0);
    chk("mrst_u2", sin_u2, 0);
    chk("mrst_aux_data", aux_data, 0);
    chk("mrst_flags", {addr_err, overrun}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
